// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcode constants and write-back source select for the 16-bit RISC pipeline
package risc_pkg;

    localparam logic [3:0] OP_ADI  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LHI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_JAL  = 4'b1001;
    localparam logic [3:0] OP_JLR  = 4'b1010;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PC2  = 2'd3
    } wb_sel_t;

endpackage

// File: rtl/wb_decode.sv
// rtl/wb_decode.sv - combinational write-back opcode decode
// Ports:
//   opcode  in   4  IR[15:12]
//   wr_en   out  1  instruction writes the register file
//   wb_sel  out  2  write-back data source
//   is_nop  out  1  instruction does not retire (NOP or undefined opcode)
module wb_decode
    import risc_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       wr_en,
    output wb_sel_t    wb_sel,
    output logic       is_nop
);

    always_comb begin
        wr_en  = 1'b0;
        wb_sel = WB_NONE;
        is_nop = 1'b0;
        case (opcode)
            OP_ADI, OP_ADD, OP_NAND, OP_LHI: begin
                wr_en  = 1'b1;
                wb_sel = WB_ALU;
            end
            OP_LW: begin
                wr_en  = 1'b1;
                wb_sel = WB_MEM;
            end
            OP_JAL, OP_JLR: begin
                wr_en  = 1'b1;
                wb_sel = WB_PC2;
            end
            OP_SW, OP_BEQ: begin
                // retire without touching the register file
            end
            default: begin
                // NOP and every unassigned opcode
                is_nop = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// rtl/wb_regfile_stage.sv - write-back stage: register file commit, bypassed reads, forwarding and retire count
// Ports:
//   clk, MEM_WB_CLR (async active-high clear)
//   WB_EN                               stage enable (0 = stall)
//   IR_IN, DEST_IN, ALU_C_IN, D_OUT_IN, PC_2_IN   MEM/WB pipeline register outputs
//   RA_ADDR/RA_DATA, RB_ADDR/RB_DATA    decode read ports with write-through bypass
//   FWD_VALID, FWD_DEST, FWD_DATA       last committed write
//   R7_WR, R7_DATA                      PC redirect notification
//   RETIRED_CNT                         retired non-NOP instruction count
module wb_regfile_stage
    import risc_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NREG  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             MEM_WB_CLR,
    input  logic             WB_EN,
    input  logic [15:0]      IR_IN,
    input  logic [2:0]       DEST_IN,
    input  logic [DW-1:0]    ALU_C_IN,
    input  logic [DW-1:0]    D_OUT_IN,
    input  logic [DW-1:0]    PC_2_IN,
    input  logic [2:0]       RA_ADDR,
    input  logic [2:0]       RB_ADDR,
    output logic [DW-1:0]    RA_DATA,
    output logic [DW-1:0]    RB_DATA,
    output logic             FWD_VALID,
    output logic [2:0]       FWD_DEST,
    output logic [DW-1:0]    FWD_DATA,
    output logic             R7_WR,
    output logic [DW-1:0]    R7_DATA,
    output logic [CNT_W-1:0] RETIRED_CNT
);

    logic [DW-1:0] regs [NREG];
    logic          wr_en;
    logic          is_nop;
    wb_sel_t       wb_sel;
    logic [DW-1:0] wb_data;
    logic          commit;
    logic          unused_ir_bits;

    assign unused_ir_bits = ^IR_IN[11:0];

    wb_decode u_decode (
        .opcode (IR_IN[15:12]),
        .wr_en  (wr_en),
        .wb_sel (wb_sel),
        .is_nop (is_nop)
    );

    always_comb begin
        wb_data = '0;
        case (wb_sel)
            WB_ALU:  wb_data = ALU_C_IN;
            WB_MEM:  wb_data = D_OUT_IN;
            WB_PC2:  wb_data = PC_2_IN;
            default: wb_data = '0;
        endcase
    end

    // Clear is asynchronous, so the combinational bypass must also be gated
    // by it; otherwise a pending write would leak through while held.
    assign commit = WB_EN && wr_en && !MEM_WB_CLR;

    always_comb begin
        RA_DATA = regs[RA_ADDR];
        RB_DATA = regs[RB_ADDR];
        if (MEM_WB_CLR) begin
            RA_DATA = '0;
            RB_DATA = '0;
        end else begin
            if (commit && RA_ADDR == DEST_IN) RA_DATA = wb_data;
            if (commit && RB_ADDR == DEST_IN) RB_DATA = wb_data;
        end
    end

    assign R7_WR   = commit && (DEST_IN == 3'd7);
    assign R7_DATA = R7_WR ? wb_data : '0;

    always_ff @(posedge clk or posedge MEM_WB_CLR) begin
        if (MEM_WB_CLR) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            FWD_VALID   <= 1'b0;
            FWD_DEST    <= '0;
            FWD_DATA    <= '0;
            RETIRED_CNT <= '0;
        end else begin
            if (commit) regs[DEST_IN] <= wb_data;
            // A non-writing instruction invalidates the forward entry; a
            // stall leaves it untouched.
            if (WB_EN) begin
                if (wr_en) begin
                    FWD_VALID <= 1'b1;
                    FWD_DEST  <= DEST_IN;
                    FWD_DATA  <= wb_data;
                end else begin
                    FWD_VALID <= 1'b0;
                end
            end
            if (WB_EN && !is_nop) RETIRED_CNT <= RETIRED_CNT + 1'b1;
        end
    end

endmodule
